// File: rtl/mux_gate_pkg.sv
// Shared definitions for the mux-gate checker: gate encodings, FSM states
// and how many input vectors each gate exercises.
package mux_gate_pkg;

    localparam logic [2:0] GATE_NOT  = 3'd0;
    localparam logic [2:0] GATE_AND  = 3'd1;
    localparam logic [2:0] GATE_OR   = 3'd2;
    localparam logic [2:0] GATE_NAND = 3'd3;
    localparam logic [2:0] GATE_NOR  = 3'd4;
    localparam logic [2:0] GATE_XOR  = 3'd5;
    localparam logic [2:0] GATE_XNOR = 3'd6;
    localparam logic [2:0] GATE_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // NOT only has input A, so it walks two vectors instead of four.
    function automatic logic [2:0] vec_count(input logic [2:0] gate_sel);
        case (gate_sel)
            GATE_NOT:  vec_count = 3'd2;
            GATE_RSVD: vec_count = 3'd0;
            default:   vec_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mux_gate_checker_if.sv
// Bundle between the checker, its controller and the gate under test.
// master = checker side, slave = controller/gate side.
interface mux_gate_checker_if;

    logic       start;
    logic [2:0] gate_sel;
    logic       dut_a;
    logic       dut_b;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        input  start, gate_sel, dut_y,
        output dut_a, dut_b, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, gate_sel, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_count, fail_vec
    );

endinterface

// File: rtl/mux_gate_ref.sv
// Golden truth table for the mux gate library, written in the same 2x1-mux
// form as the gates themselves.
module mux_gate_ref
    import mux_gate_pkg::*;
(
    input  logic [2:0] i_gate_sel,
    input  logic       i_a,
    input  logic       i_b,
    output logic       o_y
);

    always_comb begin
        o_y = 1'b0;
        case (i_gate_sel)
            GATE_NOT:  o_y = i_a ? 1'b0 : 1'b1;
            GATE_AND:  o_y = i_a ? i_b  : 1'b0;
            GATE_OR:   o_y = i_a ? 1'b1 : i_b;
            GATE_NAND: o_y = i_a ? ~i_b : 1'b1;
            GATE_NOR:  o_y = i_a ? 1'b0 : ~i_b;
            GATE_XOR:  o_y = i_a ? ~i_b : i_b;
            GATE_XNOR: o_y = i_a ? i_b  : ~i_b;
            default:   o_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_gate_checker.sv
// Drives every input vector of the selected gate, samples its output after a
// settle delay and accumulates a pass/fail verdict, error count and failure map.
module mux_gate_checker
    import mux_gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    mux_gate_checker_if.master  bus,
    output state_t              o_dbg_state
);

    localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_gate;
    logic [1:0] r_vec;
    logic [3:0] r_settle;
    logic [2:0] r_err;
    logic [3:0] r_fail;
    logic       r_pass;
    logic       r_a;
    logic       r_b;

    logic       w_exp;
    logic       w_accept;
    logic       w_sample;
    logic       w_mismatch;
    logic       w_last_vec;
    logic [1:0] w_vec_next;
    logic [2:0] w_err_next;

    mux_gate_ref u_ref (
        .i_gate_sel (r_gate),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_y        (w_exp)
    );

    assign w_accept   = (r_state == ST_IDLE) && bus.start;
    assign w_sample   = (r_state == ST_APPLY) && (r_settle == LAST_SETTLE);
    // Case inequality so an X or Z response is reported as a failure.
    assign w_mismatch = w_sample && (bus.dut_y !== w_exp);
    assign w_last_vec = ({1'b0, r_vec} == (vec_count(r_gate) - 3'd1));
    assign w_vec_next = r_vec + 2'd1;
    assign w_err_next = r_err + {2'b00, w_mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = (bus.gate_sel == GATE_RSVD) ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (w_sample && w_last_vec) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate   <= 3'd0;
            r_vec    <= 2'd0;
            r_settle <= 4'd0;
            r_err    <= 3'd0;
            r_fail   <= 4'd0;
            r_pass   <= 1'b0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
        end else if (w_accept) begin
            r_gate   <= bus.gate_sel;
            r_vec    <= 2'd0;
            r_settle <= 4'd0;
            r_err    <= 3'd0;
            r_fail   <= 4'd0;
            r_pass   <= 1'b0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
        end else if (r_state == ST_APPLY) begin
            if (w_sample) begin
                r_settle <= 4'd0;
                r_err    <= w_err_next;
                if (w_mismatch) begin
                    r_fail[r_vec] <= 1'b1;
                end
                // The final vector stays on the gate pins after the run.
                if (w_last_vec) begin
                    r_pass <= (w_err_next == 3'd0);
                end else begin
                    r_vec <= w_vec_next;
                    r_a   <= w_vec_next[0];
                    r_b   <= (r_gate == GATE_NOT) ? 1'b0 : w_vec_next[1];
                end
            end else begin
                r_settle <= r_settle + 4'd1;
            end
        end
    end

    always_comb begin
        bus.busy      = (r_state != ST_IDLE);
        bus.done      = (r_state == ST_DONE);
        bus.pass      = r_pass;
        bus.err_count = r_err;
        bus.fail_vec  = r_fail;
        bus.dut_a     = r_a;
        bus.dut_b     = r_b;
        o_dbg_state   = r_state;
    end

endmodule

// File: tb/tb_mux_gate_checker.sv
// Directed bench for mux_gate_checker: three settle settings, a behavioural
// gate model with injectable faults, and a queue of expected run results.
module tb_mux_gate_checker;
    import mux_gate_pkg::*;

    logic   clk;
    logic   rst;
    logic   [2:0] m_gate;
    logic   m_stuck;
    state_t dbg1, dbg2, dbg3;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    mux_gate_checker_if if1 ();
    mux_gate_checker_if if2 ();
    mux_gate_checker_if if3 ();

    mux_gate_checker #(.SETTLE_CYCLES(1)) u_s1 (.clk(clk), .rst(rst), .bus(if1.master), .o_dbg_state(dbg1));
    mux_gate_checker #(.SETTLE_CYCLES(2)) u_s2 (.clk(clk), .rst(rst), .bus(if2.master), .o_dbg_state(dbg2));
    mux_gate_checker #(.SETTLE_CYCLES(3)) u_s3 (.clk(clk), .rst(rst), .bus(if3.master), .o_dbg_state(dbg3));

    function automatic logic model_y(input logic [2:0] g, input logic stuck, input logic a, input logic b);
        logic y;
        case (g)
            3'd0:    y = ~a;
            3'd1:    y = a & b;
            3'd2:    y = a | b;
            3'd3:    y = ~(a & b);
            3'd4:    y = ~(a | b);
            3'd5:    y = a ^ b;
            3'd6:    y = ~(a ^ b);
            default: y = 1'b0;
        endcase
        return stuck ? 1'b1 : y;
    endfunction

    assign if1.dut_y = model_y(m_gate, m_stuck, if1.dut_a, if1.dut_b);
    assign if2.dut_y = model_y(m_gate, m_stuck, if2.dut_a, if2.dut_b);
    assign if3.dut_y = model_y(m_gate, m_stuck, if3.dut_a, if3.dut_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, done, pass, err_count[2:0], fail_vec[3:0], dut_a, dut_b}
    function automatic logic [11:0] get_out(input int k);
        case (k)
            1:       return {if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_vec, if1.dut_a, if1.dut_b};
            2:       return {if2.busy, if2.done, if2.pass, if2.err_count, if2.fail_vec, if2.dut_a, if2.dut_b};
            default: return {if3.busy, if3.done, if3.pass, if3.err_count, if3.fail_vec, if3.dut_a, if3.dut_b};
        endcase
    endfunction

    task automatic drive(input int k, input logic st, input logic [2:0] sel);
        case (k)
            1:       begin if1.start = st; if1.gate_sel = sel; end
            2:       begin if2.start = st; if2.gate_sel = sel; end
            default: begin if3.start = st; if3.gate_sel = sel; end
        endcase
    endtask

    // {done_cycle[7:0], pass, err_count[2:0], fail_vec[3:0]}
    function automatic logic [15:0] mk(input int c, input logic p, input logic [2:0] e, input logic [3:0] f);
        return {8'(c), p, e, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one test; poke>0 pulses start again in that cycle of the run.
    task automatic run(input int k, input logic [2:0] sel, input logic [2:0] mg, input logic ms,
                       input int poke, input logic [15:0] expv, output logic b_seen);
        int          cyc;
        logic [11:0] o;
        logic [15:0] e;
        m_gate  = mg;
        m_stuck = ms;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        drive(k, 1'b1, sel);
        @(posedge clk); #1;
        drive(k, 1'b0, 3'($urandom_range(0, 7)));
        cyc    = 1;
        b_seen = 1'b0;
        o      = get_out(k);
        chk("busy_cycle1", 32'(o[11]), 32'd1);
        while (cyc < 100) begin
            o = get_out(k);
            b_seen = b_seen | o[0];
            if (o[10]) break;
            @(posedge clk); #1;
            cyc++;
            drive(k, (cyc == poke), 3'($urandom_range(0, 7)));
        end
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e[15:8]));
        chk("pass", 32'(o[9]), 32'(e[7]));
        chk("err_count", 32'(o[8:6]), 32'(e[6:4]));
        chk("fail_vec", 32'(o[5:2]), 32'(e[3:0]));
        chk("busy_at_done", 32'(o[11]), 32'd1);
        @(posedge clk); #1;
        drive(k, 1'b0, 3'd0);
        o = get_out(k);
        chk("idle_after_done", 32'(o[11:10]), 32'd0);
        chk("pass_held", 32'(o[9]), 32'(e[7]));
    endtask

    initial begin
        logic        bs;
        logic [11:0] o;
        rst     = 1'b1;
        m_gate  = GATE_AND;
        m_stuck = 1'b0;
        drive(1, 1'b0, 3'd0);
        drive(2, 1'b0, 3'd0);
        drive(3, 1'b0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_s1", 32'(get_out(1)), 32'd0);
        chk("reset_s2", 32'(get_out(2)), 32'd0);
        chk("reset_s3", 32'(get_out(3)), 32'd0);
        chk("reset_state", 32'(dbg2), 32'(ST_IDLE));

        run(2, GATE_AND,  GATE_AND,  1'b0, 0, mk(9, 1'b1, 3'd0, 4'b0000), bs);
        run(2, GATE_RSVD, GATE_AND,  1'b0, 0, mk(1, 1'b0, 3'd0, 4'b0000), bs);
        run(1, GATE_NOT,  GATE_NOT,  1'b0, 0, mk(3, 1'b1, 3'd0, 4'b0000), bs);
        chk("not_b_low", 32'(bs), 32'd0);
        run(2, GATE_XOR,  GATE_XNOR, 1'b0, 9, mk(9, 1'b0, 3'd4, 4'b1111), bs);
        run(3, GATE_OR,   GATE_OR,   1'b1, 0, mk(13, 1'b0, 3'd1, 4'b0001), bs);
        run(2, GATE_NAND, GATE_NAND, 1'b0, 4, mk(9, 1'b1, 3'd0, 4'b0000), bs);
        run(1, GATE_XNOR, GATE_XNOR, 1'b0, 0, mk(5, 1'b1, 3'd0, 4'b0000), bs);

        // NOR run with an inverted gate, reset during cycle 4.
        m_gate = GATE_OR;
        @(posedge clk); #1;
        drive(2, 1'b1, GATE_NOR);
        @(posedge clk); #1;
        drive(2, 1'b0, 3'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        o = get_out(2);
        chk("nor_c4_busy", 32'(o[11]), 32'd1);
        chk("nor_c4_err", 32'(o[8:6]), 32'd1);
        chk("nor_c4_a", 32'(o[1]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("nor_c5_reset", 32'(get_out(2)), 32'd0);
        chk("nor_c5_state", 32'(dbg2), 32'(ST_IDLE));
        run(2, GATE_NOR, GATE_NOR, 1'b0, 0, mk(9, 1'b1, 3'd0, 4'b0000), bs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
